midi_note_tx: RTL and testbench
===============================

// Module: midi_note_tx
// PURPOSE
//  Encoder/transmitter end of the note-event interface used by the synth channel block.
//  Takes NoteOn/NoteOff one-shot pulses (note, velocity, channel), queues them in a small
//  FIFO and serialises each one as a MIDI 1.0 message (status, note, velocity) on a
//  31250 baud 8N1 UART line. Sits between the pad/sequencer logic and the MIDI OUT pin.
// PARAMETERS
//  pCLK_HZ      50_000_000  system clock frequency in Hz
//  pBAUD        31250       line rate; bit period DIV = pCLK_HZ/pBAUD, rounded down (1600 @ 50 MHz)
//  pFIFO_DEPTH  4           event FIFO depth; power of two, >= 2
// PORTS
//  iCLK         in   1   system clock; all logic on rising edge
//  iRST         in   1   reset, asynchronous, active-low ("L" = reset)
//  iNoteNumber  in   7   note number, sampled with iNoteOn/iNoteOff
//  iVelocity    in   7   velocity, sampled with iNoteOn/iNoteOff
//  iChannel     in   4   MIDI channel 0-15, sampled with iNoteOn/iNoteOff
//  iNoteOn      in   1   one-clock pulse: enqueue Note On
//  iNoteOff     in   1   one-clock pulse: enqueue Note Off
//  iOvfClr      in   1   one-clock pulse: clear oOverflow
//  oTxd         out  1   MIDI UART line, idle high
//  oBusy        out  1   "H" while FIFO not empty or a frame is on the line
//  oFull        out  1   "H" when FIFO holds pFIFO_DEPTH events
//  oOverflow    out  1   sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async): oTxd=1, oBusy=0, oFull=0, oOverflow=0, FIFO empty, FSM IDLE, baud/bit
//    counters 0. Reset mid-frame truncates the frame immediately; line returns high.
//  - Enqueue: entry {type,ch[3:0],note[6:0],vel[6:0]} = 19 bits, written on the pulse edge.
//    iNoteOn and iNoteOff in the same cycle: only Note Off is pushed.
//    Push while oFull=1: event dropped, oOverflow set next cycle. iOvfClr and a new drop in
//    the same cycle: set wins. Push and pop in the same cycle while full: push is accepted.
//  - Encoding: Note On status = 8'h90|ch, Note Off = 8'h80|ch; data bytes {1'b0,note},
//    {1'b0,vel}. Velocity 0 on Note On is sent unchanged (no remapping).
//  - FSM: IDLE -> LOAD (pop FIFO, latch entry, byte index=0) -> START (oTxd=0, DIV clk)
//    -> DATA (8 bits LSB first, DIV clk each) -> STOP (oTxd=1, DIV clk) -> if byte index<2:
//    index++, START; else FIFO not empty: LOAD; else IDLE.
//  - Bytes of one message and consecutive messages are back-to-back (no idle bit gap
//    beyond the single stop bit, except the one LOAD clock between messages).
//  - Latency: pulse at cycle N (FIFO empty, IDLE) -> LOAD at N+1 -> oTxd falls at N+2.
//  - Baud counter counts 0..DIV-1, wraps; bit advance on DIV-1. 3-byte message = 30 bits
//    = 30*DIV clocks (48000 @ defaults).
//  - oBusy: 1 from cycle after any accepted push until STOP of last byte completes with
//    FIFO empty; oFull/ FIFO count updated registered (one cycle after push/pop).
// CONFIGURATION
//  MIDI_RUNNING_STATUS_EN defined: block keeps last transmitted status byte (invalid after
//   reset); if a message's status equals it, the status byte is skipped (START of byte 1
//   directly after LOAD) -> 20*DIV clocks. Any status change resends and updates it.
//  Not defined: every message is always the full 3 bytes; no last-status register.
// TESTING
//  1 NoteOn ch0 note 60 vel 100 -> line bytes 8'h90,8'h3C,8'h64, each bit 1600 clk,
//    start bit at pulse+2 clk, oBusy low after 48000+2 clk.
//  2 NoteOn+NoteOff same cycle, ch3 note 64 vel 0 -> only 8'h83,8'h40,8'h00 sent.
//  3 Six pulses back-to-back, depth 4 -> first popped, four queued, oFull=1, sixth dropped,
//    oOverflow=1 until iOvfClr; five messages sent contiguously in order.
//  4 Running status EN: two NoteOn ch1 (60,100),(62,90) -> 8'h91,3C,64,3E,5A; without
//    macro -> 8'h91,3C,64,91,3E,5A.
//  5 Assert iRST low mid data bit of byte 2 -> oTxd=1 same cycle, FIFO empty, oBusy=0;
//    after release a new NoteOn transmits full 3 bytes (status resent even with EN).
//  6 Sample oTxd at mid-bit of every bit in scenarios 1-4 with a reference UART model
//    -> no framing error, stop bit always 1.

Source files
------------

// File: rtl/midi_note_tx_if.sv
// midi_note_tx_if: note-event request side and MIDI line/status side of midi_note_tx.
interface midi_note_tx_if;
    logic [6:0] iNoteNumber;
    logic [6:0] iVelocity;
    logic [3:0] iChannel;
    logic       iNoteOn;
    logic       iNoteOff;
    logic       iOvfClr;
    logic       oTxd;
    logic       oBusy;
    logic       oFull;
    logic       oOverflow;
    modport master (
        output iNoteNumber, iVelocity, iChannel, iNoteOn, iNoteOff, iOvfClr,
        input  oTxd, oBusy, oFull, oOverflow
    );
    modport slave (
        input  iNoteNumber, iVelocity, iChannel, iNoteOn, iNoteOff, iOvfClr,
        output oTxd, oBusy, oFull, oOverflow
    );
endinterface

// File: rtl/midi_note_tx.sv
// midi_note_tx: queues NoteOn/NoteOff events and sends them as 3-byte MIDI messages on an 8N1 UART.
// Define MIDI_RUNNING_STATUS_EN to omit a status byte equal to the last one transmitted.
module midi_note_tx #(
    parameter int pCLK_HZ     = 50_000_000,
    parameter int pBAUD       = 31250,
    parameter int pFIFO_DEPTH = 4
) (
    input logic           iCLK,
    input logic           iRST,
    midi_note_tx_if.slave bus
);
    localparam int DIV = pCLK_HZ / pBAUD;
    localparam int DM1 = DIV - 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(pFIFO_DEPTH);
    localparam int NW  = AW + 1;
    localparam logic [CW-1:0] DIV_M1 = DM1[CW-1:0];
    localparam logic [AW:0]   DEPTH  = pFIFO_DEPTH[AW:0];
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [18:0]   mem_q [pFIFO_DEPTH];
    logic [18:0]   mem_d [pFIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    st_q, st_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [18:0]   ent_q, ent_d;
    logic          push, push_ok, pop, full, work, tick, skip;
    logic [18:0]   new_ent, head;
    logic [7:0]    status, cur;

    // Entry layout {type(1=on), ch, note, vel}; a simultaneous on/off pair is stored as off.
    assign new_ent = {~bus.iNoteOff, bus.iChannel, bus.iNoteNumber, bus.iVelocity};
    assign head    = mem_q[rd_q];
    assign push    = bus.iNoteOn | bus.iNoteOff;
    assign pop     = st_q == LOAD;
    assign full    = cnt_q == DEPTH;
    assign push_ok = push && (!full || pop);
    assign work    = (cnt_q != '0) || push;
    assign tick    = baud_q == DIV_M1;
    assign status  = {ent_q[18] ? 4'h9 : 4'h8, ent_q[17:14]};
    assign cur     = (byte_q == 2'd0) ? status : (byte_q == 2'd1) ? {1'b0, ent_q[13:7]} : {1'b0, ent_q[6:0]};

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs_q, rs_d, head_status;
    logic       rs_v_q, rs_v_d;
    assign head_status = {head[18] ? 4'h9 : 4'h8, head[17:14]};
    assign skip        = rs_v_q && (rs_q == head_status);
    assign rs_d        = pop ? head_status : rs_q;
    assign rs_v_d      = pop | rs_v_q;
    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) begin
            rs_q   <= '0;
            rs_v_q <= 1'b0;
        end else begin
            rs_q   <= rs_d;
            rs_v_q <= rs_v_d;
        end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q] = new_ent;
        wr_d   = wr_q + AW'(push_ok);
        rd_d   = rd_q + AW'(pop);
        cnt_d  = cnt_q + NW'(push_ok) - NW'(pop);
        ovf_d  = (push && !push_ok) ? 1'b1 : bus.iOvfClr ? 1'b0 : ovf_q;
        st_d   = st_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        ent_d  = ent_q;
        baud_d = (st_q == IDLE || st_q == LOAD || tick) ? '0 : baud_q + CW'(1);
        case (st_q)
            IDLE:  st_d = work ? LOAD : IDLE;
            LOAD: begin
                st_d   = START;
                ent_d  = head;
                byte_d = skip ? 2'd1 : 2'd0;
                bit_d  = '0;
            end
            START: st_d = tick ? DATA : START;
            DATA: if (tick) begin
                bit_d = bit_q + 3'd1;
                st_d  = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                byte_d = (byte_q != 2'd2) ? byte_q + 2'd1 : byte_q;
                st_d   = (byte_q != 2'd2) ? START : work ? LOAD : IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) begin
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            st_q   <= IDLE;
            baud_q <= '0;
            bit_q  <= '0;
            byte_q <= '0;
            ent_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            st_q   <= st_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            ent_q  <= ent_d;
        end

    // Line is decoded straight from state so an async reset releases it high at once.
    assign bus.oTxd      = (st_q == START) ? 1'b0 : (st_q == DATA) ? cur[bit_q] : 1'b1;
    assign bus.oBusy     = (cnt_q != '0) || (st_q != IDLE);
    assign bus.oFull     = full;
    assign bus.oOverflow = ovf_q;
endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx: directed + randomized checks of midi_note_tx against a message-level model
// and a mid-bit sampling UART receiver.
module tb_midi_note_tx;
    localparam int CLK_HZ = 500_000;
    localparam int BAUD   = 31250;
    localparam int DIV    = CLK_HZ / BAUD;

    logic clk, rst_n;
    midi_note_tx_if bus();
    midi_note_tx #(.pCLK_HZ(CLK_HZ), .pBAUD(BAUD), .pFIFO_DEPTH(4)) dut (.iCLK(clk), .iRST(rst_n), .bus(bus));

    int n_tests = 0, n_fail = 0, cyc = 0, rx_ferr = 0;
    logic [7:0] rx_q[$], exp_q[$];
    int rx_start_q[$];
    bit exp_first[$];
    bit rx_busy = 0;
    logic [7:0] rs_last;
    bit rs_valid = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial forever @(posedge clk) cyc++;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference receiver: sample each bit at its middle, check start/stop framing.
    initial begin
        int cnt, k;
        logic [7:0] sh;
        forever begin
            @(negedge clk);
            if (!rst_n) rx_busy = 0;
            else if (!rx_busy) begin
                if (bus.oTxd === 1'b0) begin
                    rx_busy = 1;
                    cnt = 0;
                    rx_start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt >= DIV / 2 && (cnt - DIV / 2) % DIV == 0) begin
                    k = (cnt - DIV / 2) / DIV;
                    if (k == 0 && bus.oTxd !== 1'b0) rx_ferr++;
                    else if (k >= 1 && k <= 8) sh[k-1] = bus.oTxd;
                    else if (k == 9) begin
                        if (bus.oTxd !== 1'b1) rx_ferr++;
                        rx_q.push_back(sh);
                        rx_busy = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_msg(input bit on, input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v);
        logic [7:0] st;
        bit first = 1;
        st = {on ? 4'h9 : 4'h8, ch};
`ifdef MIDI_RUNNING_STATUS_EN
        if (!(rs_valid && st == rs_last)) begin
            exp_q.push_back(st);
            exp_first.push_back(1);
            first = 0;
        end
        rs_last = st;
        rs_valid = 1;
`else
        exp_q.push_back(st);
        exp_first.push_back(1);
        first = 0;
`endif
        exp_q.push_back({1'b0, n});
        exp_first.push_back(first);
        exp_q.push_back({1'b0, v});
        exp_first.push_back(0);
    endfunction

    task automatic drive(input logic on, input logic off, input logic clr, input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v);
        @(negedge clk);
        bus.iNoteOn = on;
        bus.iNoteOff = off;
        bus.iOvfClr = clr;
        bus.iChannel = ch;
        bus.iNoteNumber = n;
        bus.iVelocity = v;
    endtask

    task automatic idle1();
        drive(0, 0, 0, 4'h0, 7'h0, 7'h0);
    endtask

    task automatic clear_q();
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
        exp_first.delete();
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((bus.oBusy || rx_busy) && k < limit);
        chk("idle_timeout", {31'd0, bus.oBusy}, 32'd0);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < rx_start_q.size() && i < exp_first.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), rx_start_q[i] - rx_start_q[i-1], exp_first[i] ? 10 * DIV + 1 : 10 * DIV);
    endtask

    initial begin
        int c, k, sel;
        logic [3:0] ch;
        logic [6:0] n, v;
        rst_n = 0;
        bus.iNoteOn = 0; bus.iNoteOff = 0; bus.iOvfClr = 0;
        bus.iChannel = 0; bus.iNoteNumber = 0; bus.iVelocity = 0;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, bus.oTxd}, 32'd1);
        chk("rst_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("rst_full", {31'd0, bus.oFull}, 32'd0);
        chk("rst_ovf", {31'd0, bus.oOverflow}, 32'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("idle_txd", {31'd0, bus.oTxd}, 32'd1);

        // Single NoteOn: bytes, start latency, busy duration
        clear_q();
        drive(1, 0, 0, 4'd0, 7'd60, 7'd100);
        c = cyc;
        model_msg(1, 4'd0, 7'd60, 7'd100);
        idle1();
        chk("t1_busy_after_push", {31'd0, bus.oBusy}, 32'd1);
        while (cyc < c + 1 + 30 * DIV) @(negedge clk);
        chk("t1_busy_last", {31'd0, bus.oBusy}, 32'd1);
        @(negedge clk);
        chk("t1_busy_end", {31'd0, bus.oBusy}, 32'd0);
        wait_idle(100);
        check_bytes("t1");
        chk("t1_start_latency", rx_start_q.size() > 0 ? rx_start_q[0] - c : -1, 32'd2);
        check_gaps("t1");

        // NoteOn and NoteOff together: only the off is sent
        clear_q();
        drive(1, 1, 0, 4'd3, 7'd64, 7'd0);
        model_msg(0, 4'd3, 7'd64, 7'd0);
        idle1();
        wait_idle(40 * DIV);
        check_bytes("t2");

        // Six back-to-back pulses: 5 accepted, sixth dropped, overflow handling
        clear_q();
        for (int i = 0; i < 6; i++) begin
            ch = 4'($urandom_range(0, 15));
            n = 7'($urandom);
            v = 7'($urandom);
            sel = $urandom_range(0, 1);
            drive(sel == 1, sel == 0, 0, ch, n, v);
            if (i < 5) model_msg(sel == 1, ch, n, v);
            if (i == 5) begin
                chk("t3_full", {31'd0, bus.oFull}, 32'd1);
                chk("t3_ovf_pre", {31'd0, bus.oOverflow}, 32'd0);
            end
        end
        idle1();
        chk("t3_ovf_set", {31'd0, bus.oOverflow}, 32'd1);
        repeat (3) idle1();
        chk("t3_ovf_sticky", {31'd0, bus.oOverflow}, 32'd1);
        drive(0, 0, 1, 4'd0, 7'd0, 7'd0);
        idle1();
        chk("t3_ovf_clr", {31'd0, bus.oOverflow}, 32'd0);
        drive(1, 0, 1, 4'd7, 7'd1, 7'd1);
        idle1();
        chk("t3_set_wins", {31'd0, bus.oOverflow}, 32'd1);
        chk("t3_still_full", {31'd0, bus.oFull}, 32'd1);
        drive(0, 0, 1, 4'd0, 7'd0, 7'd0);
        idle1();
        chk("t3_ovf_clr2", {31'd0, bus.oOverflow}, 32'd0);
        wait_idle(200 * DIV);
        check_bytes("t3");
        check_gaps("t3");
        chk("t3_full_end", {31'd0, bus.oFull}, 32'd0);

        // Two NoteOn on channel 1 (running-status case)
        clear_q();
        drive(1, 0, 0, 4'd1, 7'h3C, 7'h64);
        model_msg(1, 4'd1, 7'h3C, 7'h64);
        drive(1, 0, 0, 4'd1, 7'h3E, 7'h5A);
        model_msg(1, 4'd1, 7'h3E, 7'h5A);
        idle1();
        wait_idle(80 * DIV);
        check_bytes("t4");

        // Random events with random spacing
        clear_q();
        for (int i = 0; i < 4; i++) begin
            ch = 4'($urandom_range(0, 15));
            n = 7'($urandom);
            v = 7'($urandom);
            sel = $urandom_range(0, 2);
            drive(sel != 1, sel != 0, 0, ch, n, v);
            model_msg(sel == 0, ch, n, v);
            repeat ($urandom_range(0, 3)) idle1();
        end
        idle1();
        wait_idle(150 * DIV);
        check_bytes("t5");

        // Reset in the middle of the second byte
        clear_q();
        ch = 4'($urandom_range(0, 15));
        n = 7'($urandom);
        v = 7'($urandom);
        drive(1, 0, 0, ch, n, v);
        model_msg(1, ch, n, v);
        drive(1, 0, 0, ch, n, v);
        idle1();
        while (exp_q.size() > 1) begin
            void'(exp_q.pop_back());
            void'(exp_first.pop_back());
        end
        k = 0;
        while (rx_q.size() < 1 && k < 20 * DIV) begin
            @(negedge clk);
            k++;
        end
        repeat (3 * DIV) @(negedge clk);
        chk("t6_midframe_busy", {31'd0, bus.oBusy}, 32'd1);
        rst_n = 0;
        #1;
        chk("t6_rst_txd", {31'd0, bus.oTxd}, 32'd1);
        chk("t6_rst_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("t6_rst_full", {31'd0, bus.oFull}, 32'd0);
        rs_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle1();
        check_bytes("t6_trunc");
        drive(1, 0, 0, ch, n, v);
        model_msg(1, ch, n, v);
        idle1();
        wait_idle(40 * DIV);
        check_bytes("t6");
        chk("t6_full_msg", exp_q.size(), 32'd4);
        chk("framing_errors", rx_ferr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
